// File: rtl/gpr_wb_ctl_if.sv
// Writeback bus between the ALU/LSU requesters, the arbiter and the register-file write port.
interface gpr_wb_ctl_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        gpr_we;
    logic [4:0]  gpr_rd;
    logic [31:0] gpr_di;
    logic        init_done;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, gpr_we, gpr_rd, gpr_di, init_done
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, gpr_we, gpr_rd, gpr_di, init_done
    );
endinterface

// File: rtl/gpr_wb_ctl.sv
// GPR writeback controller: clears x1..x31 after reset, then arbitrates ALU/LSU writebacks
// onto a single registered write port with a bounded-starvation LSU priority.
module gpr_wb_ctl #(
    parameter int STARVE_MAX = 3,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    gpr_wb_ctl_if.slave  bus
);
    typedef enum logic {S_INIT, S_RUN} state_t;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    localparam state_t     RST_STATE  = INIT_EN ? S_INIT : S_RUN;
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [2:0]  starve_cnt;
    logic        alu_ready, lsu_ready;
    logic        alu_acc, lsu_acc;
    wb_req_t     win;
    logic        we_q;
    logic [4:0]  rd_q;
    logic [31:0] di_q;

    // Readies are gated by rst so nothing is granted while reset is held,
    // which matters when the reset state is already RUN.
    always_comb begin
        state_nxt = state;
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        case (state)
            S_INIT: if (cnt == 5'd31) state_nxt = S_RUN;
            S_RUN: begin
                if (!rst) begin
                    if (bus.alu_valid && bus.lsu_valid) begin
                        if (starve_cnt == STARVE_LIM) alu_ready = 1'b1;
                        else                          lsu_ready = 1'b1;
                    end else begin
                        alu_ready = bus.alu_valid;
                        lsu_ready = bus.lsu_valid;
                    end
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    assign alu_acc = bus.alu_valid && alu_ready;
    assign lsu_acc = bus.lsu_valid && lsu_ready;
    assign win     = alu_acc ? wb_req_t'{bus.alu_rd, bus.alu_data}
                             : wb_req_t'{bus.lsu_rd, bus.lsu_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RST_STATE;
            cnt        <= 5'd1;
            starve_cnt <= 3'd0;
            we_q       <= 1'b0;
            rd_q       <= 5'd0;
            di_q       <= 32'd0;
        end else begin
            state <= state_nxt;
            we_q  <= 1'b0;
            if (state == S_INIT) begin
                cnt  <= cnt + 5'd1;
                we_q <= 1'b1;
                rd_q <= cnt;
                di_q <= 32'd0;
            end else if (alu_acc || lsu_acc) begin
                // x0 is hardwired: the handshake completes but no write is issued
                we_q <= |win.rd;
                rd_q <= win.rd;
                di_q <= win.data;
                if (alu_acc)               starve_cnt <= 3'd0;
                else if (bus.alu_valid)    starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

    assign bus.alu_ready = alu_ready;
    assign bus.lsu_ready = lsu_ready;
    assign bus.gpr_we    = we_q;
    assign bus.gpr_rd    = rd_q;
    assign bus.gpr_di    = di_q;
    assign bus.init_done = (state == S_RUN);
endmodule

// File: tb/tb_gpr_wb_ctl.sv
// Bench for gpr_wb_ctl: clear sweep, arbitration table with a writeback scoreboard, reset aborts.
module tb_gpr_wb_ctl;
    logic clk;
    logic rst;

    gpr_wb_ctl_if if1 ();
    gpr_wb_ctl_if if2 ();

    gpr_wb_ctl #(.STARVE_MAX(3), .INIT_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(if1));
    gpr_wb_ctl #(.STARVE_MAX(3), .INIT_EN(1'b0)) dut_ni (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          av;
        logic [4:0]  ard;
        logic [31:0] ad;
        bit          lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        bit          exp_ar;
        bit          exp_lr;
    } vec_t;

    typedef struct {
        bit          we;
        bit          known;
        logic [4:0]  rd;
        logic [31:0] di;
    } wb_exp_t;

    wb_exp_t     sb[$];
    logic [4:0]  exp_rd;
    logic [31:0] exp_di;
    bit          exp_known;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                                input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                                input bit ear, input bit elr);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.exp_ar = ear; v.exp_lr = elr;
        return v;
    endfunction

    task automatic drive_idle();
        if1.alu_valid = 1'b0; if1.alu_rd = 5'd0; if1.alu_data = 32'd0;
        if1.lsu_valid = 1'b0; if1.lsu_rd = 5'd0; if1.lsu_data = 32'd0;
    endtask

    // One RUN cycle: drive, check readies mid-cycle, predict the write, check it after the edge.
    task automatic step(input vec_t v);
        wb_exp_t e;
        if1.alu_valid = v.av; if1.alu_rd = v.ard; if1.alu_data = v.ad;
        if1.lsu_valid = v.lv; if1.lsu_rd = v.lrd; if1.lsu_data = v.ld;
        @(negedge clk);
        chk("alu_ready", 32'(if1.alu_ready), 32'(v.exp_ar));
        chk("lsu_ready", 32'(if1.lsu_ready), 32'(v.exp_lr));
        if (v.exp_ar || v.exp_lr) begin
            exp_rd    = v.exp_ar ? v.ard : v.lrd;
            exp_di    = v.exp_ar ? v.ad  : v.ld;
            e.we      = (exp_rd != 5'd0);
            exp_known = e.we;
        end else begin
            e.we = 1'b0;
        end
        e.known = exp_known; e.rd = exp_rd; e.di = exp_di;
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            chk("gpr_we", 32'(if1.gpr_we), 32'(e.we));
            if (e.known) begin
                chk("gpr_rd", 32'(if1.gpr_rd), 32'(e.rd));
                chk("gpr_di", if1.gpr_di, e.di);
            end
        end
    endtask

    // Clear sweep after a reset release; abort_at>0 re-asserts reset after that write.
    task automatic sweep(input bit with_valid, input int abort_at);
        if (with_valid) begin
            if1.alu_valid = 1'b1; if1.alu_rd = 5'd20; if1.alu_data = 32'h55;
            if1.lsu_valid = 1'b1; if1.lsu_rd = 5'd21; if1.lsu_data = 32'h66;
        end
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk); #1;
            chk("init_we", 32'(if1.gpr_we), 32'(1));
            chk("init_rd", 32'(if1.gpr_rd), 32'(i));
            chk("init_di", if1.gpr_di, 32'd0);
            if (i < 31) begin
                chk("init_done_lo", 32'(if1.init_done), 32'(0));
                chk("init_alu_ready", 32'(if1.alu_ready), 32'(0));
                chk("init_lsu_ready", 32'(if1.lsu_ready), 32'(0));
            end
            if (i == 30) drive_idle();
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_we", 32'(if1.gpr_we), 32'(0));
                chk("abort_rd", 32'(if1.gpr_rd), 32'(0));
                drive_idle();
                return;
            end
        end
        @(posedge clk); #1;
        chk("post_init_we", 32'(if1.gpr_we), 32'(0));
        chk("post_init_done", 32'(if1.init_done), 32'(1));
    endtask

    vec_t tbl[16];

    initial begin
        // starve_cnt trace for both-valid rows: 0->1->2->3->ALU(0)->1 ...
        tbl[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,    1, 0);
        tbl[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 0);
        tbl[2]  = mk(1, 5'd9,  32'hA,        1, 5'd7,  32'h1,    0, 1);
        tbl[3]  = mk(1, 5'd9,  32'hA,        1, 5'd8,  32'h2,    0, 1);
        tbl[4]  = mk(1, 5'd9,  32'hA,        1, 5'd10, 32'h3,    0, 1);
        tbl[5]  = mk(1, 5'd9,  32'hA,        1, 5'd10, 32'h4,    1, 0);
        tbl[6]  = mk(1, 5'd14, 32'hB,        1, 5'd11, 32'h4,    0, 1);
        tbl[7]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h1234, 0, 1);
        tbl[8]  = mk(1, 5'd14, 32'hB,        1, 5'd12, 32'h5,    0, 1);
        tbl[9]  = mk(1, 5'd1,  32'h11,       0, 5'd0,  32'h0,    1, 0);
        tbl[10] = mk(1, 5'd2,  32'h22,       0, 5'd0,  32'h0,    1, 0);
        tbl[11] = mk(1, 5'd3,  32'h33,       0, 5'd0,  32'h0,    1, 0);
        tbl[12] = mk(1, 5'd15, 32'hC,        1, 5'd13, 32'h6,    0, 1);
        tbl[13] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 0);
        tbl[14] = mk(1, 5'd0,  32'hFFFF,     0, 5'd0,  32'h0,    1, 0);
        tbl[15] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 0);

        rst = 1'b0;
        drive_idle();
        if2.alu_valid = 1'b1; if2.alu_rd = 5'd4; if2.alu_data = 32'h44;
        if2.lsu_valid = 1'b0; if2.lsu_rd = 5'd0; if2.lsu_data = 32'd0;
        #1 rst = 1'b1;
        if1.alu_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(if1.gpr_we), 32'(0));
        chk("rst_rd", 32'(if1.gpr_rd), 32'(0));
        chk("rst_di", if1.gpr_di, 32'd0);
        chk("rst_done", 32'(if1.init_done), 32'(0));
        chk("rst_alu_ready", 32'(if1.alu_ready), 32'(0));
        chk("ni_rst_done", 32'(if2.init_done), 32'(1));
        chk("ni_rst_alu_ready", 32'(if2.alu_ready), 32'(0));
        drive_idle();
        rst = 1'b0;

        sweep(1'b0, 0);

        exp_rd = 5'd31; exp_di = 32'd0; exp_known = 1'b1;
        for (int i = 0; i < 16; i++) step(tbl[i]);

        // Pending ALU request caught by reset must never reach the register file.
        if1.alu_valid = 1'b1; if1.alu_rd = 5'd20; if1.alu_data = 32'h55;
        #2;
        chk("pend_alu_ready", 32'(if1.alu_ready), 32'(1));
        rst = 1'b1;
        #1;
        chk("pend_rst_ready", 32'(if1.alu_ready), 32'(0));
        chk("pend_rst_we", 32'(if1.gpr_we), 32'(0));
        @(posedge clk); #1;
        chk("pend_hold_we", 32'(if1.gpr_we), 32'(0));
        drive_idle();
        @(negedge clk) rst = 1'b0;

        sweep(1'b1, 11);
        @(posedge clk); #1;
        chk("abort_hold_we", 32'(if1.gpr_we), 32'(0));
        @(negedge clk) rst = 1'b0;
        sweep(1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // INIT_EN=0 instance: RUN straight out of reset, first request accepted on the first edge.
    initial begin
        @(negedge rst);
        @(posedge clk); #1;
        chk("ni_we", 32'(if2.gpr_we), 32'(1));
        chk("ni_rd", 32'(if2.gpr_rd), 32'(4));
        chk("ni_di", if2.gpr_di, 32'h44);
        if2.alu_valid = 1'b0;
        @(posedge clk); #1;
        chk("ni_we_off", 32'(if2.gpr_we), 32'(0));
        chk("ni_done", 32'(if2.init_done), 32'(1));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
